// File: rtl/alu_ctrl_mdu_pkg.sv
// rtl/alu_ctrl_mdu_pkg.sv - shared constants, encodings and FSM state type for the ALU control / MDU block
package alu_ctrl_mdu_pkg;

    // Instruction opcodes seen by the decode path.
    localparam logic [6:0] OPC_ARITHMETIC     = 7'b0110011;
    localparam logic [6:0] OPC_ARITHMETIC_IMM = 7'b0010011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // M-extension funct3 encodings.
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // alu_op encodings from the control unit.
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

    // alu_control = {prefix[1:0], funct7[5], funct3}.
    localparam logic [5:0] CTL_ADD    = 6'b000000;
    localparam logic [1:0] CTL_BRANCH = 2'b01;
    localparam logic [1:0] CTL_IMM    = 2'b10;
    localparam logic [1:0] CTL_REG    = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/alu_ctrl_mdu_mdu_iter_core.sv
// rtl/alu_ctrl_mdu_mdu_iter_core.sv - iterative radix-2 multiply/divide engine with FSM and counter
//
// Ports:
//   clk, reset_n      core clock, synchronous active-low reset
//   start             accept a new operation this cycle (operands/op valid)
//   kill              flush: return to IDLE, suppress result
//   op                funct3 of the M-extension instruction
//   a, b              operands (rs1, rs2)
//   busy              engine not IDLE
//   result_valid      one-cycle completion pulse
//   result            final result; holds the last completed value otherwise
module alu_ctrl_mdu_mdu_iter_core
    import alu_ctrl_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // {hi, lo} is the 2*XLEN accumulator: product for multiply,
    // {partial remainder, dividend/quotient} for divide.
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            special_q, special_d;

    // Operand sign handling at start.
    logic            is_div, signed_a, signed_b, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;

    // Iteration datapath.
    logic [XLEN:0]     mul_sum, div_trial, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod, prod_c;
    logic [XLEN-1:0]   div_sel, div_res, final_res;

    always_comb begin
        is_div   = op[2];
        // MULHU and unsigned divides treat A as unsigned; B is signed only for MUL/MULH and DIV/REM.
        signed_a = is_div ? ~op[0] : ~(op[1] & op[0]);
        signed_b = is_div ? ~op[0] : ~op[1];
        a_neg    = signed_a & a[XLEN-1];
        b_neg    = signed_b & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = is_div && (b == '0);
        div_ovf  = is_div && signed_a && (a == MOST_NEG) && (b == '1);
    end

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        div_trial = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_trial - {1'b0, opb_q};
        div_ge    = div_trial >= {1'b0, opb_q};

        prod    = {hi_q, lo_q};
        prod_c  = neg_q ? -prod : prod;
        div_sel = op_q[1] ? hi_q : lo_q;
        // Special-case results were loaded already corrected.
        div_res = (neg_q && !special_q) ? -div_sel : div_sel;

        if (op_q[2]) begin
            final_res = div_res;
        end else if (op_q == F3_MUL) begin
            final_res = prod_c[XLEN-1:0];
        end else begin
            final_res = prod_c[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        opb_d        = opb_q;
        op_d         = op_q;
        neg_d        = neg_q;
        special_d    = special_q;
        result_d     = result_q;
        result_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = op;
                    // REM takes the dividend's sign; everything else the product of signs.
                    neg_d     = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
                    cnt_d     = CNT_W'(XLEN);
                    hi_d      = '0;
                    lo_d      = a_mag;
                    opb_d     = b_mag;
                    special_d = 1'b0;
                    state_d   = CALC;
                    if (div_zero) begin
                        special_d = 1'b1;
                        hi_d      = a;
                        lo_d      = '1;
                        state_d   = DONE;
                    end else if (div_ovf) begin
                        special_d = 1'b1;
                        hi_d      = '0;
                        lo_d      = MOST_NEG;
                        state_d   = DONE;
                    end
                end
            end
            CALC: begin
                if (op_q[2]) begin
                    hi_d = div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], div_ge};
                end else begin
                    {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                result_d     = final_res;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (kill) begin
            state_d      = IDLE;
            result_valid = 1'b0;
            result_d     = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            special_q <= special_d;
        end
    end

    assign busy   = (state_q != IDLE);
    // Result is visible in the completion cycle itself, then held in result_q.
    assign result = result_valid ? final_res : result_q;

endmodule

// File: rtl/alu_ctrl_mdu.sv
// rtl/alu_ctrl_mdu.sv - ALUOp/funct decode plus RV32M multiply/divide engine with stall handshake
//
// Ports:
//   clk, reset_n              core clock, synchronous active-low reset
//   valid_in, kill            instruction valid in execute, pipeline flush
//   alu_op, opcode, funct3/7  control-unit and instruction fields
//   rs1_val, rs2_val          operands
//   alu_control               {prefix, funct7[5], funct3} to the ALU
//   mdu_sel                   instruction is an M-extension op
//   stall                     hold PC/IR/operands this cycle
//   busy, result_valid        engine status and completion pulse
//   mdu_result                multiply/divide result
module alu_ctrl_mdu
    import alu_ctrl_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            valid_in,
    input  logic            kill,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [5:0]      alu_control,
    output logic            mdu_sel,
    output logic            stall,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] mdu_result
);

    logic start;

    always_comb begin
        alu_control = CTL_ADD;
        mdu_sel     = 1'b0;
        case (alu_op)
            ALU_OP_BRANCH: alu_control = {CTL_BRANCH, funct7[5], funct3};
            ALU_OP_FUNCT: begin
                if (opcode == OPC_ARITHMETIC && funct7 == FUNCT7_MULDIV) begin
                    mdu_sel = 1'b1;
                end else if (opcode == OPC_ARITHMETIC_IMM) begin
                    alu_control = {CTL_IMM, funct7[5], funct3};
                end else begin
                    alu_control = {CTL_REG, funct7[5], funct3};
                end
            end
            default: alu_control = CTL_ADD;
        endcase
    end

    // busy blocks re-issue while the same instruction sits in execute.
    assign start = valid_in & mdu_sel & ~busy & ~kill;
    assign stall = valid_in & mdu_sel & ~result_valid;

    alu_ctrl_mdu_mdu_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .kill         (kill),
        .op           (funct3),
        .a            (rs1_val),
        .b            (rs2_val),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (mdu_result)
    );

endmodule
